// File: rtl/exception_unit_pkg.sv
// -----------------------------------------------------------------------------
// exception_unit_pkg
// Shared CPU definitions for the exception sequencer. It holds the FSM state
// encoding, the cause index constants and the default handler-vector base
// address.
// -----------------------------------------------------------------------------
package exception_unit_pkg;

  // Exception sequencer states; the encoding is fixed and shared with the CPU.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    READ    = 3'd2,
    WAIT    = 3'd3,
    LOAD    = 3'd4
  } exc_state_e;

  // Cause indices at the default three-source configuration.
  localparam int EXC_OPCODE   = 0;
  localparam int EXC_OVERFLOW = 1;
  localparam int EXC_DIV0     = 2;

  // Byte address of the cause-0 handler vector.
  localparam int DEFAULT_VECTOR_BASE = 253;

endpackage

// File: rtl/exc_priority_enc.sv
// -----------------------------------------------------------------------------
// exc_priority_enc
// Combinational highest-set-bit encoder for simultaneous exception requests.
// Ports:
//   req  in   N_CAUSES  request vector, bit i is cause i
//   any  out  1         at least one request bit set
//   idx  out  IDX_W     index of the highest set bit (0 when none set)
// -----------------------------------------------------------------------------
module exc_priority_enc #(
  parameter int N_CAUSES = 3,
  parameter int IDX_W    = (N_CAUSES > 1) ? $clog2(N_CAUSES) : 1
) (
  input  logic [N_CAUSES-1:0] req,
  output logic                any,
  output logic [IDX_W-1:0]    idx
);

  // Ascending scan, so the highest set index is the last one written.
  always_comb begin
    any = |req;
    idx = {IDX_W{1'b0}};
    for (int i = 0; i < N_CAUSES; i++) begin
      idx = req[i] ? IDX_W'(i) : idx;
    end
  end

endmodule

// File: rtl/exception_unit.sv
// -----------------------------------------------------------------------------
// exception_unit
// Sequencing exception controller for the multicycle CPU. It prioritises
// simultaneous requests and captures EPC and the cause code. It then reads the
// handler-vector byte from memory and loads it, zero-extended, into PC.
// Ports:
//   clk       in   1         system clock, rising edge
//   reset     in   1         asynchronous active-high reset
//   exc_req   in   N_CAUSES  one-cycle request pulses, bit i is cause i
//   pc_in     in   DATA_W    PC of the instruction after the faulting one
//   mem_byte  in   8         memory read data, low byte
//   mem_addr  out  DATA_W    vector address to memory
//   mem_rd    out  1         memory read strobe
//   pc_out    out  DATA_W    new PC (mem_byte zero-extended)
//   pc_load   out  1         one-cycle PC write enable
//   epc       out  DATA_W    exception PC register
//   cause     out  CAUSE_W   index of the last serviced cause
//   busy      out  1         sequence in progress, control FSM must stall
// -----------------------------------------------------------------------------
module exception_unit
  import exception_unit_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int N_CAUSES    = 3,
  parameter int VECTOR_BASE = DEFAULT_VECTOR_BASE,
  parameter int MEM_WAIT    = 1,
  localparam int CAUSE_W    = (N_CAUSES > 1) ? $clog2(N_CAUSES) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_CAUSES-1:0] exc_req,
  input  logic [DATA_W-1:0]   pc_in,
  input  logic [7:0]          mem_byte,
  output logic [DATA_W-1:0]   mem_addr,
  output logic                mem_rd,
  output logic [DATA_W-1:0]   pc_out,
  output logic                pc_load,
  output logic [DATA_W-1:0]   epc,
  output logic [CAUSE_W-1:0]  cause,
  output logic                busy
);

  exc_state_e          state_r;
  exc_state_e          next_state_s;
  logic [CAUSE_W-1:0]  sel_r;
  logic [3:0]          cnt_r;
  logic                any_s;
  logic [CAUSE_W-1:0]  idx_s;
  logic [DATA_W-1:0]   vec_addr_s;

  exc_priority_enc #(
    .N_CAUSES (N_CAUSES),
    .IDX_W    (CAUSE_W)
  ) u_prio (
    .req (exc_req),
    .any (any_s),
    .idx (idx_s)
  );

  assign vec_addr_s = DATA_W'(VECTOR_BASE) + {{(DATA_W-CAUSE_W){1'b0}}, sel_r};

  // State register plus the per-state captures: selected cause, EPC/cause and wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      sel_r   <= {CAUSE_W{1'b0}};
      cnt_r   <= 4'd0;
      epc     <= {DATA_W{1'b0}};
      cause   <= {CAUSE_W{1'b0}};
    end else begin
      state_r <= next_state_s;
      case (state_r)
        IDLE: begin
          if (any_s) sel_r <= idx_s;
          else       sel_r <= sel_r;
        end
        CAPTURE: begin
          // pc_in already points past the faulting instruction; wraps modulo 2^DATA_W.
          epc   <= pc_in - DATA_W'(32'd4);
          cause <= sel_r;
        end
        READ:    cnt_r <= 4'(MEM_WAIT - 1);
        WAIT:    cnt_r <= (cnt_r == 4'd0) ? 4'd0 : cnt_r - 4'd1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Next-state decode; requests are only sampled in IDLE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_s) next_state_s = CAPTURE;
        else       next_state_s = IDLE;
      end
      CAPTURE: next_state_s = READ;
      READ: begin
        if (MEM_WAIT == 1) next_state_s = LOAD;
        else               next_state_s = WAIT;
      end
      WAIT: begin
        // The decrement that takes the counter to zero is the last wait cycle.
        if (cnt_r <= 4'd1) next_state_s = LOAD;
        else               next_state_s = WAIT;
      end
      LOAD:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode of the current state; pc_out passes mem_byte through in LOAD.
  always_comb begin
    mem_rd   = 1'b0;
    mem_addr = {DATA_W{1'b0}};
    pc_load  = 1'b0;
    pc_out   = {DATA_W{1'b0}};
    busy     = 1'b1;
    case (state_r)
      IDLE:    busy = 1'b0;
      CAPTURE: busy = 1'b1;
      READ: begin
        mem_rd   = 1'b1;
        mem_addr = vec_addr_s;
      end
      WAIT:    mem_addr = vec_addr_s;
      LOAD: begin
        mem_addr = vec_addr_s;
        pc_load  = 1'b1;
        pc_out   = {{(DATA_W-8){1'b0}}, mem_byte};
      end
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_exception_unit.sv
// -----------------------------------------------------------------------------
// tb_exception_unit
// Self-checking bench for exception_unit. Instance a uses MEM_WAIT=1 and
// instance b uses MEM_WAIT=4. A transaction-level model predicts every output
// on every cycle from the request time. Directed sequences add hand-computed
// literal expectations.
// -----------------------------------------------------------------------------
module tb_exception_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a, reset_b;
  logic [2:0]  req_a, req_b;
  logic [31:0] pc_a, pc_b;
  logic [7:0]  mb_a, mb_b;
  logic [31:0] addr_a, addr_b, pco_a, pco_b, epc_a, epc_b;
  logic        rd_a, rd_b, ld_a, ld_b, busy_a, busy_b;
  logic [1:0]  cause_a, cause_b;

  exception_unit u_a (
    .clk(clk), .reset(reset_a), .exc_req(req_a), .pc_in(pc_a), .mem_byte(mb_a),
    .mem_addr(addr_a), .mem_rd(rd_a), .pc_out(pco_a), .pc_load(ld_a),
    .epc(epc_a), .cause(cause_a), .busy(busy_a)
  );

  exception_unit #(.MEM_WAIT(4)) u_b (
    .clk(clk), .reset(reset_b), .exc_req(req_b), .pc_in(pc_b), .mem_byte(mb_b),
    .mem_addr(addr_b), .mem_rd(rd_b), .pc_out(pco_b), .pc_load(ld_b),
    .epc(epc_b), .cause(cause_b), .busy(busy_b)
  );

  int npass  = 0;
  int ntotal = 0;
  bit done   = 1'b0;

  // Transaction model: one in-flight exception per instance, timed from its request edge.
  int          cyc = 0;
  bit          act_m   [2];
  int          t0_m    [2];
  int          sel_m   [2];
  logic [31:0] epc_m   [2];
  int          cause_m [2];
  int          loads   [2];

  function automatic int mw(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic int top_bit(input logic [2:0] r);
    int h = -1;
    for (int k = 0; k < 3; k++) if (r[k]) h = k;
    return h;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Model update on each rising edge.
  initial begin
    for (int i = 0; i < 2; i++) begin
      act_m[i] = 1'b0; t0_m[i] = 0; sel_m[i] = 0;
      epc_m[i] = 32'h0; cause_m[i] = 0; loads[i] = 0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        logic        rs;
        logic [2:0]  rq;
        logic [31:0] pc;
        rs = (i == 0) ? reset_a : reset_b;
        rq = (i == 0) ? req_a   : req_b;
        pc = (i == 0) ? pc_a    : pc_b;
        if (rs) begin
          act_m[i] = 1'b0; epc_m[i] = 32'h0; cause_m[i] = 0;
        end else if (act_m[i]) begin
          if (cyc - t0_m[i] == 0) begin
            epc_m[i]   = pc - 32'd4;
            cause_m[i] = sel_m[i];
          end
          if (cyc - t0_m[i] == mw(i) + 1) act_m[i] = 1'b0;
        end else if (rq != 3'b000) begin
          act_m[i] = 1'b1;
          t0_m[i]  = cyc + 1;
          sel_m[i] = top_bit(rq);
        end
      end
      cyc++;
    end
  end

  task automatic check_inst(input int i, input logic rs, input logic [31:0] addr,
                            input logic rd, input logic [31:0] pco, input logic ld,
                            input logic [31:0] epc, input logic [1:0] cs,
                            input logic bz, input logic [7:0] mb);
    string s;
    int    p;
    bit    a;
    bit    in_load;
    s = (i == 0) ? "a" : "b";
    if (rs) begin
      chk({s, ".rst.busy"}, 32'(bz), 32'd0);
      chk({s, ".rst.mem_rd"}, 32'(rd), 32'd0);
      chk({s, ".rst.pc_load"}, 32'(ld), 32'd0);
      chk({s, ".rst.mem_addr"}, addr, 32'd0);
      chk({s, ".rst.pc_out"}, pco, 32'd0);
      chk({s, ".rst.epc"}, epc, 32'd0);
      chk({s, ".rst.cause"}, 32'(cs), 32'd0);
    end else begin
      p       = cyc - t0_m[i];
      a       = act_m[i];
      in_load = a && (p == mw(i) + 1);
      chk({s, ".busy"}, 32'(bz), 32'(a));
      chk({s, ".mem_rd"}, 32'(rd), 32'(a && (p == 1)));
      chk({s, ".pc_load"}, 32'(ld), 32'(in_load));
      chk({s, ".pc_out"}, pco, in_load ? {24'h0, mb} : 32'h0);
      if (!a) chk({s, ".mem_addr_idle"}, addr, 32'd0);
      else if (p >= 1 && p <= mw(i)) chk({s, ".mem_addr"}, addr, 32'(253 + sel_m[i]));
      chk({s, ".epc"}, epc, epc_m[i]);
      chk({s, ".cause"}, 32'(cs), 32'(cause_m[i]));
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!done) begin
        check_inst(0, reset_a, addr_a, rd_a, pco_a, ld_a, epc_a, cause_a, busy_a, mb_a);
        check_inst(1, reset_b, addr_b, rd_b, pco_b, ld_b, epc_b, cause_b, busy_b, mb_b);
        if (ld_a === 1'b1) loads[0]++;
        if (ld_b === 1'b1) loads[1]++;
      end
    end
  end

  // One default-latency exception on instance a with literal expectations.
  task automatic run_a(input logic [2:0] r, input logic [31:0] pc, input logic [7:0] mb,
                       input logic [31:0] exp_addr, input logic [31:0] exp_epc,
                       input logic [31:0] exp_cause, input logic [31:0] exp_pco);
    @(posedge clk); #2 req_a = r; pc_a = pc; mb_a = mb;
    @(posedge clk); #2 req_a = 3'b000;
    @(negedge clk); #1 chk("a.lit.busy_capture", 32'(busy_a), 32'd1);
    @(negedge clk); #1 chk("a.lit.mem_rd", 32'(rd_a), 32'd1);
    chk("a.lit.mem_addr", addr_a, exp_addr);
    @(negedge clk); #1 chk("a.lit.pc_load", 32'(ld_a), 32'd1);
    chk("a.lit.pc_out", pco_a, exp_pco);
    chk("a.lit.epc", epc_a, exp_epc);
    chk("a.lit.cause", 32'(cause_a), exp_cause);
    @(posedge clk); #2;
  endtask

  initial begin
    reset_a = 1'b1; reset_b = 1'b1;
    req_a = 3'b000; req_b = 3'b000;
    pc_a = 32'h0; pc_b = 32'h0; mb_a = 8'h00; mb_b = 8'h00;
    repeat (2) @(posedge clk);
    #2 reset_a = 1'b0; reset_b = 1'b0;
    #1 chk("a.lit.reset_epc", epc_a, 32'h0);
    chk("a.lit.reset_busy", 32'(busy_a), 32'd0);
    chk("b.lit.reset_mem_addr", addr_b, 32'h0);

    // Single overflow, priority, lowest cause, EPC wraparound.
    run_a(3'b010, 32'h0000_0040, 8'h7C, 32'd254, 32'h0000_003C, 32'd1, 32'h0000_007C);
    run_a(3'b111, 32'h0000_1000, 8'h20, 32'd255, 32'h0000_0FFC, 32'd2, 32'h0000_0020);
    run_a(3'b001, 32'h0000_2004, 8'h31, 32'd253, 32'h0000_2000, 32'd0, 32'h0000_0031);
    run_a(3'b100, 32'h0000_0000, 8'h05, 32'd255, 32'hFFFF_FFFC, 32'd2, 32'h0000_0005);

    // Second request while busy is ignored.
    @(posedge clk); #2 req_a = 3'b010; pc_a = 32'h0000_0100; mb_a = 8'h44;
    @(posedge clk); #2 req_a = 3'b000;
    @(posedge clk); #2 req_a = 3'b100; pc_a = 32'h0000_0200;
    @(posedge clk); #2 req_a = 3'b000;
    @(negedge clk); #1 chk("a.lit.ign_pc_load", 32'(ld_a), 32'd1);
    chk("a.lit.ign_epc", epc_a, 32'h0000_00FC);
    repeat (3) @(posedge clk);
    @(negedge clk); #1 chk("a.lit.ign_epc_hold", epc_a, 32'h0000_00FC);
    chk("a.lit.ign_cause_hold", 32'(cause_a), 32'd1);
    chk("a.lit.ign_busy", 32'(busy_a), 32'd0);

    // MEM_WAIT=4, vector byte valid only during LOAD.
    @(posedge clk); #2 req_b = 3'b001; pc_b = 32'h0000_0080; mb_b = 8'h00;
    @(posedge clk); #2 req_b = 3'b000;
    @(negedge clk); #1 chk("b.lit.busy_capture", 32'(busy_b), 32'd1);
    @(negedge clk); #1 chk("b.lit.mem_rd", 32'(rd_b), 32'd1);
    chk("b.lit.mem_addr", addr_b, 32'd253);
    repeat (3) @(posedge clk);
    #1 chk("b.lit.wait_pc_load", 32'(ld_b), 32'd0);
    chk("b.lit.wait_mem_rd", 32'(rd_b), 32'd0);
    chk("b.lit.wait_mem_addr", addr_b, 32'd253);
    @(posedge clk); #2 mb_b = 8'hFF;
    @(negedge clk); #1 chk("b.lit.pc_load", 32'(ld_b), 32'd1);
    chk("b.lit.pc_out", pco_b, 32'h0000_00FF);
    chk("b.lit.epc", epc_b, 32'h0000_007C);
    chk("b.lit.cause", 32'(cause_b), 32'd0);
    @(posedge clk); #2 mb_b = 8'h00;

    // Reset in WAIT: outputs clear at once and the pending load never appears.
    @(posedge clk); #2 req_b = 3'b100; pc_b = 32'h0000_0300;
    @(posedge clk); #2 req_b = 3'b000;
    repeat (2) @(posedge clk);
    #2 reset_b = 1'b1;
    #1 chk("b.lit.ar_busy", 32'(busy_b), 32'd0);
    chk("b.lit.ar_mem_addr", addr_b, 32'd0);
    chk("b.lit.ar_epc", epc_b, 32'd0);
    chk("b.lit.ar_cause", 32'(cause_b), 32'd0);
    chk("b.lit.ar_pc_load", 32'(ld_b), 32'd0);
    @(posedge clk); #2 reset_b = 1'b0;
    repeat (6) @(posedge clk);

    // A fresh request after reset is serviced normally.
    #2 req_b = 3'b010; pc_b = 32'h0000_0500; mb_b = 8'h5A;
    @(posedge clk); #2 req_b = 3'b000;
    repeat (5) @(posedge clk);
    @(negedge clk); #1 chk("b.lit.post_pc_load", 32'(ld_b), 32'd1);
    chk("b.lit.post_pc_out", pco_b, 32'h0000_005A);
    chk("b.lit.post_epc", epc_b, 32'h0000_04FC);
    chk("b.lit.post_cause", 32'(cause_b), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("a.lit.load_count", 32'(loads[0]), 32'd5);
    chk("b.lit.load_count", 32'(loads[1]), 32'd2);
    done = 1'b1;
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/exception_unit.md
# exception_unit

Sequencing exception controller for the multicycle CPU. It replaces the fixed 3-way exception-vector select with a parametrised N-cause unit that:
- prioritises simultaneous requests;
- captures EPC and the cause code;
- drives the handler-vector byte read from memory;
- loads the zero-extended byte into PC.

It sits beside the main control FSM, which stalls while `busy` is high.

## Interface
Parameters:
- `DATA_W`, 32, PC/EPC/address width
- `N_CAUSES`, 3, number of exception sources; bit i of `exc_req` is cause i
- `VECTOR_BASE`, 253, memory byte address of the cause-0 vector; cause i reads `VECTOR_BASE + i`
- `MEM_WAIT`, 1, cycles between read issue and valid `mem_byte` (1..15)

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `exc_req`  in  N_CAUSES  one-cycle request pulses (0 opcode, 1 overflow, 2 div0 at default)
- `pc_in`  in  DATA_W  PC of the next instruction, i.e. the faulting instruction's PC + 4
- `mem_byte`  in  8  memory read data, low byte
- `mem_addr`  out  DATA_W  vector address to memory
- `mem_rd`  out  1  memory read strobe
- `pc_out`  out  DATA_W  new PC: `mem_byte` zero-extended
- `pc_load`  out  1  one-cycle PC write enable
- `epc`  out  DATA_W  exception PC register
- `cause`  out  $clog2(N_CAUSES)  index of the last serviced cause
- `busy`  out  1  high from the capture cycle through the load cycle

## Operation
- FSM states: IDLE, CAPTURE, READ, WAIT, LOAD.
- IDLE: if any `exc_req` bit is set, latch the highest-index set bit into the internal `sel` register, then go to CAPTURE. Higher index wins, so div0 beats overflow beats opcode.
- CAPTURE:
  - `epc <= pc_in - 4`, with subtraction modulo 2^DATA_W (pc_in = 0 gives 0xFFFF_FFFC);
  - `cause <= sel`;
  - next state READ.
- READ: `mem_rd = 1`, `mem_addr = VECTOR_BASE + sel`. Load the wait counter with `MEM_WAIT - 1`, then go to WAIT, or to LOAD directly if `MEM_WAIT == 1`.
- WAIT: decrement the counter; go to LOAD when it reaches 0. `mem_addr` is held and `mem_rd = 0`.
- LOAD: `pc_out = {DATA_W-8 zeros, mem_byte}`, `pc_load = 1` for exactly this cycle; next state IDLE.
- Requests arriving while not in IDLE are ignored. There is no queueing and no nesting; the control FSM must not issue them.
- A request in the same cycle the FSM returns to IDLE is sampled on the following edge.
- `epc` and `cause` hold their values until the next exception's CAPTURE.

## Timing
- Reset values:
  - state IDLE;
  - `epc`, `cause`, `mem_addr`, `pc_out` all 0;
  - `mem_rd`, `pc_load`, `busy` all 0;
  - counter 0.
- `mem_rd`, `pc_load`, `busy`, `mem_addr` and `pc_out` are combinational decodes of registered state and registers. `pc_out` additionally passes `mem_byte` through in LOAD.
- Latency from the request edge to the `pc_load` cycle is `MEM_WAIT + 2` cycles: 3 at default. At default `busy` is high for 3 cycles.
- Reset asserted mid-sequence returns the FSM to IDLE immediately; the `pc_load` that was in flight is never issued.
- `pc_in` is sampled only in CAPTURE.

## Structure
- The shared CPU package holds:
  - state encoding constants (IDLE=0, CAPTURE=1, READ=2, WAIT=3, LOAD=4);
  - the cause index constants (EXC_OPCODE=0, EXC_OVERFLOW=1, EXC_DIV0=2);
  - the default `VECTOR_BASE`.
- One sub-module, `exc_priority_enc`, parametrised by N_CAUSES: a combinational highest-set-bit encoder with outputs `any` and `idx`.

## Test plan
- Reset, then `exc_req`=3'b010 with `pc_in`=0x0000_0040 and `mem_byte`=0x7C:
  - `mem_rd` high with `mem_addr`=254;
  - `pc_load` with `pc_out`=0x0000_007C 3 cycles after the request;
  - `epc`=0x3C, `cause`=1.
- Simultaneous `exc_req`=3'b111: `mem_addr`=255, `cause`=2. Then `exc_req`=3'b001 gives `mem_addr`=253, `cause`=0.
- `pc_in`=0: `epc`=0xFFFF_FFFC.
- A second request pulse while `busy`: ignored; exactly one `pc_load`, and `epc`/`cause` unchanged.
- `MEM_WAIT`=4, `mem_byte`=0xFF valid only in the LOAD cycle: `pc_load` 6 cycles after the request, `pc_out`=0x0000_00FF.
- `reset` asserted in the WAIT state: all outputs return to 0 asynchronously; no `pc_load` follows; a new request is serviced normally afterwards.
